// File: rtl/multi_requester.sv
// multi_requester: per-channel ready -> delayed request generator.
// Each channel runs an independent IDLE/WAIT/REQ FSM. The request delay is
// clamped to [MIN_DLY, MAX_DLY]. Readies arriving while a channel is busy
// are reported as one-cycle drop pulses.
// Optional feature macro: MULTI_REQUESTER_DROP_CNT_EN adds saturating
// 8-bit per-channel drop counters on output drop_cnt.
module multi_requester #(
  parameter int CH_NUM    = 4,
  parameter int DLY_W     = 4,
  parameter int MIN_DLY   = 1,
  parameter int MAX_DLY   = 10,
  parameter int HOLD_MODE = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [CH_NUM-1:0]       ready,
  input  logic [CH_NUM*DLY_W-1:0] delay,
  input  logic [CH_NUM-1:0]       ack,
`ifdef MULTI_REQUESTER_DROP_CNT_EN
  output logic [CH_NUM*8-1:0]     drop_cnt,
`endif
  output logic [CH_NUM-1:0]       request,
  output logic [CH_NUM-1:0]       busy,
  output logic [CH_NUM-1:0]       drop
);

  // Reject parameter sets the clamp and countdown cannot represent.
  if (CH_NUM < 1 || DLY_W < 1 || MIN_DLY < 1 || MAX_DLY < MIN_DLY ||
      MAX_DLY > (2**DLY_W) - 1 || (HOLD_MODE != 0 && HOLD_MODE != 1)) begin : g_bad_param
    $error("multi_requester: illegal parameter combination");
  end

  localparam logic [DLY_W-1:0] MIN_V = DLY_W'(MIN_DLY);
  localparam logic [DLY_W-1:0] MAX_V = DLY_W'(MAX_DLY);
  localparam logic [DLY_W-1:0] ONE_V = DLY_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_REQ  = 2'd2
  } state_t;

  for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
    state_t           state, state_nx;
    logic [DLY_W-1:0] cnt, cnt_nx;
    logic [DLY_W-1:0] dly_raw, dly_clamp;
    logic             drop_q;
    logic             drop_hit;

    assign dly_raw  = delay[g*DLY_W +: DLY_W];
    assign drop_hit = ready[g] && (state != S_IDLE);

    // Clamp the requested delay into [MIN_DLY, MAX_DLY] without wrapping.
    always_comb begin
      dly_clamp = dly_raw;
      if (dly_raw < MIN_V)
        dly_clamp = MIN_V;
      else if (dly_raw > MAX_V)
        dly_clamp = MAX_V;
    end

    // State, countdown and drop flag registers.
    always_ff @(posedge clk) begin
      if (rst) begin
        state  <= S_IDLE;
        cnt    <= '0;
        drop_q <= 1'b0;
      end else begin
        state  <= state_nx;
        cnt    <= cnt_nx;
        drop_q <= drop_hit;
      end
    end

    // Next-state logic. WAIT is loaded with d-1 so REQ lands in cycle k+d.
    always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      unique case (state)
        S_IDLE: begin
          if (ready[g]) begin
            if (dly_clamp == ONE_V) begin
              state_nx = S_REQ;
            end else begin
              state_nx = S_WAIT;
              cnt_nx   = dly_clamp - ONE_V;
            end
          end
        end
        S_WAIT: begin
          cnt_nx = cnt - ONE_V;
          if (cnt == ONE_V)
            state_nx = S_REQ;
        end
        S_REQ: begin
          if (HOLD_MODE == 0 || ack[g])
            state_nx = S_IDLE;
        end
        default: begin
          state_nx = S_IDLE;
          cnt_nx   = '0;
        end
      endcase
    end

    assign request[g] = (state == S_REQ);
    assign busy[g]    = (state != S_IDLE);
    assign drop[g]    = drop_q;

`ifdef MULTI_REQUESTER_DROP_CNT_EN
    logic [7:0] dcnt;

    // Saturating drop counter; advances on the same edge that raises drop.
    always_ff @(posedge clk) begin
      if (rst)
        dcnt <= '0;
      else if (drop_hit && dcnt != 8'hFF)
        dcnt <= dcnt + 8'd1;
    end

    assign drop_cnt[g*8 +: 8] = dcnt;
`endif
  end

endmodule

// File: tb/tb_multi_requester.sv
// Self-checking bench for multi_requester: a pulse-mode and a hold-mode
// instance share stimulus and are compared every cycle against a
// cycle-number based reference model, plus directed latency checks.
module tb_multi_requester;

  localparam int CH  = 4;
  localparam int W   = 4;
  localparam int MIN = 1;
  localparam int MAX = 10;
  localparam int BIG = 1 << 30;

  logic            clk;
  logic            rst;
  logic [CH-1:0]   ready;
  logic [CH*W-1:0] delay;
  logic [CH-1:0]   ack;
  logic [CH-1:0]   req0, busy0, drop0;
  logic [CH-1:0]   req1, busy1, drop1;
`ifdef MULTI_REQUESTER_DROP_CNT_EN
  logic [CH*8-1:0] dcnt0, dcnt1;
`endif

  multi_requester #(.CH_NUM(CH), .DLY_W(W), .MIN_DLY(MIN), .MAX_DLY(MAX), .HOLD_MODE(0)) u0 (
    .clk(clk), .rst(rst), .ready(ready), .delay(delay), .ack(ack),
`ifdef MULTI_REQUESTER_DROP_CNT_EN
    .drop_cnt(dcnt0),
`endif
    .request(req0), .busy(busy0), .drop(drop0));

  multi_requester #(.CH_NUM(CH), .DLY_W(W), .MIN_DLY(MIN), .MAX_DLY(MAX), .HOLD_MODE(1)) u1 (
    .clk(clk), .rst(rst), .ready(ready), .delay(delay), .ack(ack),
`ifdef MULTI_REQUESTER_DROP_CNT_EN
    .drop_cnt(dcnt1),
`endif
    .request(req1), .busy(busy1), .drop(drop1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model, per instance u and channel i, in absolute cycle numbers:
  // armed channel requests from req_at and is idle again from rel on.
  bit arm    [2][CH];
  int req_at [2][CH];
  int rel    [2][CH];
  bit dn     [2][CH];
  int dc     [2][CH];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int clampd(input int v);
    return (v < MIN) ? MIN : ((v > MAX) ? MAX : v);
  endfunction

  function automatic bit mbusy(input int u, input int i, input int c);
    return arm[u][i] && (c < rel[u][i]);
  endfunction

  // Apply the inputs sampled at this edge to the model (cycle cyc -> cyc+1).
  task automatic model_edge();
    for (int u = 0; u < 2; u++) begin
      for (int i = 0; i < CH; i++) begin
        if (rst) begin
          arm[u][i] = 1'b0;
          dn[u][i]  = 1'b0;
          dc[u][i]  = 0;
        end else begin
          bit b;
          b = mbusy(u, i, cyc);
          dn[u][i] = ready[i] && b;
          if (dn[u][i] && dc[u][i] < 255) dc[u][i]++;
          if (ready[i] && !b) begin
            int d;
            d = clampd(int'(delay[i*W +: W]));
            arm[u][i]    = 1'b1;
            req_at[u][i] = cyc + d;
            rel[u][i]    = (u == 1) ? BIG : cyc + d + 1;
          end else if (u == 1 && b && cyc >= req_at[u][i] && ack[i]) begin
            rel[u][i] = cyc + 1;
          end
        end
      end
    end
    cyc++;
  endtask

  // One clock: DUT and model advance, then every output is compared.
  task automatic step();
    logic [CH-1:0] er, eb, ed;
    @(posedge clk);
    #1;
    model_edge();
    for (int u = 0; u < 2; u++) begin
`ifdef MULTI_REQUESTER_DROP_CNT_EN
      logic [CH*8-1:0] ec;
`endif
      for (int i = 0; i < CH; i++) begin
        eb[i] = mbusy(u, i, cyc);
        er[i] = eb[i] && (cyc >= req_at[u][i]);
        ed[i] = dn[u][i];
`ifdef MULTI_REQUESTER_DROP_CNT_EN
        ec[i*8 +: 8] = 8'(dc[u][i]);
`endif
      end
      if (u == 0) begin
        check("u0.request", 32'(req0), 32'(er));
        check("u0.busy", 32'(busy0), 32'(eb));
        check("u0.drop", 32'(drop0), 32'(ed));
`ifdef MULTI_REQUESTER_DROP_CNT_EN
        check("u0.drop_cnt", dcnt0, ec);
`endif
      end else begin
        check("u1.request", 32'(req1), 32'(er));
        check("u1.busy", 32'(busy1), 32'(eb));
        check("u1.drop", 32'(drop1), 32'(ed));
`ifdef MULTI_REQUESTER_DROP_CNT_EN
        check("u1.drop_cnt", dcnt1, ec);
`endif
      end
    end
  endtask

  task automatic idle(input int n);
    ready = '0;
    ack   = '0;
    for (int j = 0; j < n; j++) step();
  endtask

  task automatic release_all();
    ready = '0;
    ack   = '1;
    step();
    ack   = '0;
    step();
  endtask

  // Pulse ready on one channel of u0 and measure cycles to the first request.
  task automatic lat_check(input int ch, input int dly, input int expd, input string tag);
    int first;
    first = -1;
    delay = '0;
    delay[ch*W +: W] = W'(dly);
    ready = '0;
    ready[ch] = 1'b1;
    step();
    ready = '0;
    for (int n = 1; n <= 14; n++) begin
      if (first < 0 && req0[ch]) first = n;
      step();
    end
    check(tag, 32'(first), 32'(expd));
  endtask

  initial begin
    int first [CH];
    int nreq;
    bit seen;

    rst = 1'b1; ready = '0; delay = '0; ack = '0;
    for (int u = 0; u < 2; u++)
      for (int i = 0; i < CH; i++) begin
        arm[u][i] = 1'b0; dn[u][i] = 1'b0; dc[u][i] = 0;
        req_at[u][i] = 0; rel[u][i] = 0;
      end
    // Reset holds everything low even with ready/ack active.
    ready = '1; ack = '1; delay = '1;
    step(); step(); step();
    rst = 1'b0;
    idle(2);

    // Basic latency and clamp behaviour.
    lat_check(0, 3, 3, "lat_d3");
    lat_check(0, 0, 1, "lat_clamp_lo");
    lat_check(0, 15, 10, "lat_clamp_hi");
    lat_check(2, 10, 10, "lat_d10");
    release_all();

    // A second ready while waiting is dropped and does not move the request.
    delay = '0;
    delay[1*W +: W] = 4'd6;
    ready = 4'b0010;
    step();
    ready = '0;
    step();
    ready = 4'b0010;
    step();
    ready = '0;
    check("drop_ch1", 32'(drop0[1]), 32'd1);
    first[1] = -1; nreq = 0;
    for (int n = 3; n <= 12; n++) begin
      if (req0[1]) begin
        nreq++;
        if (first[1] < 0) first[1] = n;
      end
      step();
    end
    check("drop_req_cycle", 32'(first[1]), 32'd6);
    check("drop_req_count", 32'(nreq), 32'd1);
    release_all();
    idle(2);

    // Hold mode: request stays up until ack, then drops the next cycle.
    delay = '0;
    delay[2*W +: W] = 4'd2;
    ready = 4'b0100;
    step();
    ready = '0;
    step();
    for (int n = 0; n < 5; n++) step();
    check("hold_req_high", 32'(req1[2]), 32'd1);
    ack = 4'b0100;
    step();
    ack = '0;
    check("hold_req_low", 32'(req1[2]), 32'd0);
    check("hold_busy_low", 32'(busy1[2]), 32'd0);
    ack = '1;
    step();
    ack = '0;
    step();
    check("ack_idle_busy", 32'(busy1), 32'd0);

    // Reset during WAIT aborts the channel for good.
    delay = '0;
    delay[3*W +: W] = 4'd5;
    ready = 4'b1000;
    step();
    ready = '0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_busy", 32'(busy0[3]), 32'd0);
    seen = 1'b0;
    for (int n = 0; n < 18; n++) begin
      if (req0[3] || req1[3]) seen = 1'b1;
      step();
    end
    check("rst_no_req", 32'(seen), 32'd0);

    // All channels at once with distinct delays.
    delay = {4'd10, 4'd7, 4'd4, 4'd1};
    ready = '1;
    step();
    ready = '0;
    for (int i = 0; i < CH; i++) first[i] = -1;
    for (int n = 1; n <= 12; n++) begin
      for (int i = 0; i < CH; i++)
        if (first[i] < 0 && req0[i]) first[i] = n;
      step();
    end
    check("multi_ch0", 32'(first[0]), 32'd1);
    check("multi_ch1", 32'(first[1]), 32'd4);
    check("multi_ch2", 32'(first[2]), 32'd7);
    check("multi_ch3", 32'(first[3]), 32'd10);
    release_all();

    // Park u1 channel 0 in REQ and hammer it with readies to saturate drops.
    delay = '0;
    ready = 4'b0001;
    for (int n = 0; n < 302; n++) step();
    ready = '0;
    step();
`ifdef MULTI_REQUESTER_DROP_CNT_EN
    check("drop_cnt_sat", 32'(dcnt1[7:0]), 32'd255);
`endif
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle(2);

    // Random traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      rst   = ($urandom_range(0, 199) == 0);
      ready = CH'($urandom & $urandom);
      delay = (CH*W)'($urandom);
      ack   = CH'($urandom & $urandom);
      step();
    end
    idle(12);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/multi_requester.md
Name: multi_requester

Overview:
- Parametrised, multi-channel successor to the single-channel ready/request generator.
- Each channel watches its own `ready` pulse and issues `request` after a delay chosen per channel and clamped to [MIN_DLY, MAX_DLY].
- A hold mode keeps `request` high until `ack` returns.
- Readies that arrive while a channel is busy are flagged as drops.
- Used as a stimulus and handshake source in verification benches and as a small arbitration front-end.

Parameters:
- CH_NUM, 4: number of independent channels.
- DLY_W, 4: width of each per-channel delay field.
- MIN_DLY, 1: lower clamp of the request delay, in cycles; must be >= 1.
- MAX_DLY, 10: upper clamp of the request delay, in cycles; must satisfy MIN_DLY <= MAX_DLY <= 2**DLY_W-1.
- HOLD_MODE, 0: 0 = request is a 1-cycle pulse; 1 = request held until ack.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- ready  in  CH_NUM  per-channel trigger, sampled on posedge clk.
- delay  in  CH_NUM*DLY_W  per-channel delay; channel i uses bits [i*DLY_W +: DLY_W]; sampled with ready.
- ack  in  CH_NUM  per-channel acknowledge; used only when HOLD_MODE=1.
- request  out  CH_NUM  per-channel request.
- busy  out  CH_NUM  channel is not IDLE.
- drop  out  CH_NUM  1-cycle pulse: a ready was ignored.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset:
  - request, busy and drop are 0; every channel FSM is IDLE; counters are cleared.
  - rst overrides ready and ack in the same cycle.
  - rst asserted mid-operation aborts the channel; no request is issued afterwards.
- Channel independence: channels share no state. Simultaneous events on different channels never interact.
- Delay clamp: d = delay_i < MIN_DLY ? MIN_DLY : (delay_i > MAX_DLY ? MAX_DLY : delay_i). Compute in DLY_W bits with no wrap.
- Per-channel FSM has three states: IDLE, WAIT, REQ.
  - IDLE:
    - ready[i]=1 at an edge captures d.
    - If d==1, go directly to REQ; otherwise go to WAIT with the countdown loaded.
  - WAIT: counter decrements each cycle; go to REQ so that request[i] is high in exactly the d-th cycle after the ready cycle.
  - REQ:
    - request[i]=1.
    - HOLD_MODE=0: stay one cycle, then IDLE.
    - HOLD_MODE=1: stay until ack[i]=1 is sampled, then IDLE. request is low in the cycle after ack.
- Latency: ready high in cycle k → request high in cycle k+d, for d in [MIN_DLY, MAX_DLY].
- busy[i]: high in cycles k+1 through the last request cycle, inclusive.
- ready while not IDLE (WAIT or REQ, including the last REQ cycle):
  - The ready is ignored and the current timing is unchanged.
  - drop[i] is high in the next cycle.
  - A channel re-arms only from IDLE; there is no back-to-back re-arm in the REQ cycle.
- ack outside REQ, or with HOLD_MODE=0: ignored, with no side effects.
- Parameter checks: an illegal parameter combination raises an elaboration-time $error.

Optional Feature:
- Macro: MULTI_REQUESTER_DROP_CNT_EN.
- When defined:
  - Adds output drop_cnt, CH_NUM*8 bits.
  - Per channel, an 8-bit counter increments on every drop pulse and saturates at 255 (no wrap).
  - Cleared by rst only.
  - A drop and rst in the same cycle give 0.
- When undefined: the port and counters are absent; only the drop pulse is provided.

Test Plan:
1. Defaults, ready[0] pulse in cycle k with delay0=3 → request[0]=1 only in cycle k+3; busy[0]=1 in k+1..k+3; drop=0.
2. delay0=0 → request in k+1 (clamped to 1). delay0=15 → request in k+10 (clamped to 10).
3. delay1=6, second ready[1] at k+2 → drop[1]=1 in k+3; request[1] still in k+6 only. With MULTI_REQUESTER_DROP_CNT_EN, drop_cnt[1]=1, and saturates at 255 after 300 drops.
4. HOLD_MODE=1, delay=2, ack low for 5 cycles after request rises → request stays 1. ack=1 → request=0 next cycle, busy=0. ack pulsed while IDLE → no change.
5. rst=1 at k+2 during WAIT (delay=5) → busy=0 in k+3; no request through k+20.
6. All 4 channels ready in the same cycle with delays 1, 4, 7, 10 → requests in k+1, k+4, k+7, k+10 respectively. Assertion `ready[i] && !busy[i] |-> ##[MIN_DLY:MAX_DLY] request[i]` holds over 1000 random readies.
